// File: rtl/cond_logic_unit.sv
// cond_logic_unit: ARM condition check, NZCV flags register and strobe gating.
// Define COND_PERF_CNT_EN to build the executed/skipped performance counters.
module cond_logic_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic             stall_i,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             clr_cnt_i,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] exec_cnt_o,
   output logic [CNT_W-1:0] skip_cnt_o
);

   logic [3:0] flags_q, flags_d;
   logic       accept;
   logic       n, z, c, v;

   assign accept       = valid_i & ~stall_i & rst_n;
   assign {n, z, c, v} = flags_q;

   // Evaluated against the registered flags, never the in-flight ALU result.
   always_comb begin
      CondEx = 1'b0;
      unique case (Cond)
         4'b0000: CondEx = z;
         4'b0001: CondEx = ~z;
         4'b0010: CondEx = c;
         4'b0011: CondEx = ~c;
         4'b0100: CondEx = n;
         4'b0101: CondEx = ~n;
         4'b0110: CondEx = v;
         4'b0111: CondEx = ~v;
         4'b1000: CondEx = c & ~z;
         4'b1001: CondEx = ~c | z;
         4'b1010: CondEx = (n == v);
         4'b1011: CondEx = (n != v);
         4'b1100: CondEx = ~z & (n == v);
         4'b1101: CondEx = z | (n != v);
         4'b1110: CondEx = 1'b1;
         4'b1111: CondEx = 1'b0;
      endcase
   end

   assign PCSrc    = PCS  & CondEx & accept;
   assign RegWrite = RegW & CondEx & accept;
   assign MemWrite = MemW & CondEx & accept;

   always_comb begin
      flags_d = flags_q;
      if (accept & CondEx) begin
         if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
         if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= 4'b0000;
      else        flags_q <= flags_d;
   end

   assign Flags = flags_q;

`ifdef COND_PERF_CNT_EN
   logic [CNT_W-1:0] exec_q, exec_d;
   logic [CNT_W-1:0] skip_q, skip_d;

   // Clear wins over a same-cycle increment.
   always_comb begin
      exec_d = exec_q;
      skip_d = skip_q;
      if (clr_cnt_i) begin
         exec_d = '0;
         skip_d = '0;
      end else if (accept) begin
         if (CondEx) exec_d = exec_q + 1'b1;
         else        skip_d = skip_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_q <= '0;
         skip_q <= '0;
      end else begin
         exec_q <= exec_d;
         skip_q <= skip_d;
      end
   end

   assign exec_cnt_o = exec_q;
   assign skip_cnt_o = skip_q;
`else
   logic unused_clr;
   assign unused_clr = clr_cnt_i;
   assign exec_cnt_o = '0;
   assign skip_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cond_logic_unit.sv
// Self-checking bench for cond_logic_unit: reference model plus directed vectors.
// Narrow counters under COND_PERF_CNT_EN make the wrap reachable quickly.
module tb_cond_logic_unit;

`ifdef COND_PERF_CNT_EN
   localparam int CW = 4;
`else
   localparam int CW = 32;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_i = 1'b0;
   logic          stall_i = 1'b0;
   logic [3:0]    Cond = 4'hE;
   logic [3:0]    ALUFlags = 4'h0;
   logic [1:0]    FlagW = 2'b00;
   logic          PCS = 1'b0;
   logic          RegW = 1'b0;
   logic          MemW = 1'b0;
   logic          clr_cnt_i = 1'b0;
   logic          PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0]    Flags;
   logic [CW-1:0] exec_cnt_o, skip_cnt_o;

   int nvec = 0;
   int nerr = 0;

   cond_logic_unit #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .stall_i(stall_i),
      .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS),
      .RegW(RegW), .MemW(MemW), .clr_cnt_i(clr_cnt_i), .PCSrc(PCSrc),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Flags(Flags), .exec_cnt_o(exec_cnt_o), .skip_cnt_o(skip_cnt_o)
   );

   always #5 clk = ~clk;

   // ARM rule: pairs of conditions share a base test, odd code inverts it.
   function automatic bit cond_ok(logic [3:0] cc, logic [3:0] f);
      bit fn, fz, fc, fv, base;
      fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
      case (cc[3:1])
         3'd0: base = fz;
         3'd1: base = fc;
         3'd2: base = fn;
         3'd3: base = fv;
         3'd4: base = fc && !fz;
         3'd5: base = (fn == fv);
         3'd6: base = !fz && (fn == fv);
         default: base = 1'b1;
      endcase
      if (cc == 4'hF) return 1'b0;
      return cc[0] ? !base : base;
   endfunction

   logic [3:0]    m_flags = 4'h0;
   logic [CW-1:0] m_exec = '0;
   logic [CW-1:0] m_skip = '0;

   always @(posedge clk or negedge rst_n) begin
      logic [3:0] msk;
      bit acc, ok;
      if (!rst_n) begin
         m_flags = 4'h0;
         m_exec  = '0;
         m_skip  = '0;
      end else begin
         acc = valid_i && !stall_i;
         ok  = cond_ok(Cond, m_flags);
         msk = {{2{FlagW[1]}}, {2{FlagW[0]}}};
`ifdef COND_PERF_CNT_EN
         if (clr_cnt_i) begin
            m_exec = '0;
            m_skip = '0;
         end else if (acc) begin
            if (ok) m_exec = m_exec + 1'b1;
            else    m_skip = m_skip + 1'b1;
         end
`endif
         if (acc && ok) m_flags = (m_flags & ~msk) | (ALUFlags & msk);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      bit acc, ok;
      acc = valid_i && !stall_i && rst_n;
      ok  = cond_ok(Cond, m_flags);
      chk("m_CondEx",   32'(CondEx),   32'(ok));
      chk("m_PCSrc",    32'(PCSrc),    32'(PCS  && ok && acc));
      chk("m_RegWrite", 32'(RegWrite), 32'(RegW && ok && acc));
      chk("m_MemWrite", 32'(MemWrite), 32'(MemW && ok && acc));
      chk("m_Flags",    32'(Flags),    32'(m_flags));
      chk("m_exec",     32'(exec_cnt_o), 32'(m_exec));
      chk("m_skip",     32'(skip_cnt_o), 32'(m_skip));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_i = 0; stall_i = 0; PCS = 0; RegW = 0; MemW = 0;
      FlagW = 2'b00; clr_cnt_i = 0; Cond = 4'hE;
   endtask

`ifdef COND_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   initial begin
      logic [31:0] e;
      // In reset, an always-condition write must stay gated.
      valid_i = 1; RegW = 1; Cond = 4'hE;
      @(negedge clk);
      chk("rst_RegWrite", 32'(RegWrite), 32'd0);
      chk("rst_Flags", 32'(Flags), 32'h0);
      step();
      rst_n = 1;
      @(negedge clk);
      chk("al_RegWrite", 32'(RegWrite), 32'd1);
      chk("al_Flags", 32'(Flags), 32'h0);
      step();

      // ADDS setting Z, then BEQ / BNE.
      FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1; Cond = 4'hE;
      step();
      idle(); valid_i = 1; PCS = 1; Cond = 4'h0;
      @(negedge clk);
      chk("beq_Flags", 32'(Flags), 32'h4);
      chk("beq_PCSrc", 32'(PCSrc), 32'd1);
      step();
      Cond = 4'h1;
      @(negedge clk);
      chk("bne_PCSrc", 32'(PCSrc), 32'd0);
      step();
      idle();
      @(negedge clk);
      e = PERF ? 32'd1 : 32'd0;
      chk("bne_skip", 32'(skip_cnt_o), e);
      e = PERF ? 32'd3 : 32'd0;
      chk("bne_exec", 32'(exec_cnt_o), e);

      // Clear flags, then C,V-only write.
      valid_i = 1; FlagW = 2'b11; ALUFlags = 4'h0;
      step();
      FlagW = 2'b01; ALUFlags = 4'hF;
      step();
      idle(); Cond = 4'hA;
      @(negedge clk);
      chk("cv_Flags", 32'(Flags), 32'h3);
      chk("ge_CondEx", 32'(CondEx), 32'd0);
      step();
      Cond = 4'h8;
      @(negedge clk);
      chk("hi_CondEx", 32'(CondEx), 32'd1);
      step();
      Cond = 4'hB;
      @(negedge clk);
      chk("lt_CondEx", 32'(CondEx), 32'd1);
      step();

      // Store held by a 3-cycle stall.
      idle(); valid_i = 1; MemW = 1; stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_MemWrite", 32'(MemWrite), 32'd0);
         step();
      end
      stall_i = 0;
      @(negedge clk);
      chk("go_MemWrite", 32'(MemWrite), 32'd1);
      step();
      idle();

      // Every condition against every flag value.
      for (int f = 0; f < 16; f++) begin
         idle(); valid_i = 1; FlagW = 2'b11; ALUFlags = 4'(f);
         step();
         idle();
         for (int cc = 0; cc < 16; cc++) begin
            Cond = 4'(cc);
            @(negedge clk);
            if (cc == 15) chk("nv_CondEx", 32'(CondEx), 32'd0);
            if (cc == 14) chk("al_sweep", 32'(CondEx), 32'd1);
            step();
         end
      end

      // Clear with simultaneous accept, then wrap at the counter width.
      idle(); valid_i = 1; clr_cnt_i = 1;
      step();
      idle();
      @(negedge clk);
      chk("clr_exec", 32'(exec_cnt_o), 32'd0);
      chk("clr_skip", 32'(skip_cnt_o), 32'd0);
      step();
      valid_i = 1;
      repeat ((1 << 4) - 1) step();
      idle();
      @(negedge clk);
      e = PERF ? 32'd15 : 32'd0;
      chk("pre_wrap", 32'(exec_cnt_o), e);
      step();
      valid_i = 1;
      step();
      idle();
      @(negedge clk);
      e = PERF ? ((1 << CW) > 16 ? 32'd16 : 32'd0) : 32'd0;
      chk("wrap_exec", 32'(exec_cnt_o), e);
      step();

      // Asynchronous reset during a stall with flags 1111.
      chk("pre_rst_Flags", 32'(Flags), 32'hF);
      valid_i = 1; stall_i = 1; RegW = 1; Cond = 4'hE;
      #2 rst_n = 0;
      #1;
      chk("arst_Flags", 32'(Flags), 32'h0);
      chk("arst_al", 32'(CondEx), 32'd1);
      chk("arst_RegWrite", 32'(RegWrite), 32'd0);
      chk("arst_exec", 32'(exec_cnt_o), 32'd0);
      stall_i = 0;
      #1;
      chk("arst_RegWrite2", 32'(RegWrite), 32'd0);
      Cond = 4'h0;
      #1;
      chk("arst_eq", 32'(CondEx), 32'd0);
      step();
      rst_n = 1;
      Cond = 4'hE;
      @(negedge clk);
      chk("post_rst_RegWrite", 32'(RegWrite), 32'd1);
      step();
      idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
